// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. All status is registered from count_d.
module sync_fifo_flags #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = (1 << ASIZE) - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   input  logic             clr_err,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic [DSIZE-1:0] rdata,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_C  = DEPTH[ASIZE:0];
   localparam logic [ASIZE:0] AFULL_C  = AFULL_TH[ASIZE:0];
   localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_TH[ASIZE:0];
   localparam logic [ASIZE:0] ONE_C    = {{ASIZE{1'b0}}, 1'b1};

   logic [DSIZE-1:0] mem [DEPTH];

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic [ASIZE:0]   count_q, count_d;
   logic [DSIZE-1:0] rdata_q, rdata_d;
   logic             wfull_q, wfull_d;
   logic             rempty_q, rempty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      rd_ok    = rinc & ~rempty_q;
      // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
      wr_ok    = winc & (~wfull_q | rd_ok);
      wptr_d   = wr_ok ? wptr_q + ONE_C : wptr_q;
      rptr_d   = rd_ok ? rptr_q + ONE_C : rptr_q;
      rdata_d  = rd_ok ? mem[rptr_q[ASIZE-1:0]] : rdata_q;
      count_d  = count_q + {{ASIZE{1'b0}}, wr_ok} - {{ASIZE{1'b0}}, rd_ok};
      wfull_d  = (count_d == DEPTH_C);
      rempty_d = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
      // A new error in the clearing cycle takes priority over clr_err.
      ovf_d    = (ovf_q & ~clr_err) | (winc & wfull_q & ~rd_ok);
      udf_d    = (udf_q & ~clr_err) | (rinc & rempty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is not reset; writes in a reset cycle are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok) begin
         mem[wptr_q[ASIZE-1:0]] <= wdata;
      end
   end

   assign wfull         = wfull_q;
   assign rempty        = rempty_q;
   assign walmost_full  = afull_q;
   assign ralmost_empty = aempty_q;
   assign count         = count_q;
   assign rdata         = rdata_q;
   assign overflow      = ovf_q;
   assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       winc;
   logic [7:0] wdata;
   logic       rinc;
   logic       clr_err;
   logic       wfull;
   logic       rempty;
   logic       walmost_full;
   logic       ralmost_empty;
   logic [4:0] count;
   logic [7:0] rdata;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   sync_fifo_flags #(
      .DSIZE     (8),
      .ASIZE     (4),
      .AFULL_TH  (14),
      .AEMPTY_TH (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .winc          (winc),
      .wdata         (wdata),
      .rinc          (rinc),
      .clr_err       (clr_err),
      .wfull         (wfull),
      .rempty        (rempty),
      .walmost_full  (walmost_full),
      .ralmost_empty (ralmost_empty),
      .count         (count),
      .rdata         (rdata),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00; clr_err = 1'b0;

      // reset with random requests
      for (int i = 0; i < 4; i++) begin
         winc  = 1'($urandom_range(1));
         rinc  = 1'($urandom_range(1));
         wdata = 8'($urandom_range(255));
         tick();
      end
      chk("rst_count", 32'(count), 0);
      chk("rst_rempty", 32'(rempty), 1);
      chk("rst_aempty", 32'(ralmost_empty), 1);
      chk("rst_wfull", 32'(wfull), 0);
      chk("rst_afull", 32'(walmost_full), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);
      rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
      tick();

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         winc = 1'b1; wdata = 8'(i);
         tick();
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_afull", 32'(walmost_full), (i + 1 >= 14) ? 1 : 0);
         chk("fill_wfull", 32'(wfull), (i == 15) ? 1 : 0);
         chk("fill_rempty", 32'(rempty), 0);
      end

      // overflow while full
      winc = 1'b1; wdata = 8'hEE;
      tick();
      winc = 1'b0;
      chk("ovf_count", 32'(count), 16);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_wfull", 32'(wfull), 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
      chk("ovf_clr_count", 32'(count), 16);

      // drain in order
      for (int i = 0; i < 16; i++) begin
         rinc = 1'b1;
         tick();
         chk("drain_rdata", 32'(rdata), 32'(i));
         chk("drain_count", 32'(count), 32'(15 - i));
         chk("drain_rempty", 32'(rempty), (i == 15) ? 1 : 0);
         chk("drain_aempty", 32'(ralmost_empty), (15 - i <= 2) ? 1 : 0);
         chk("drain_wfull", 32'(wfull), 0);
      end
      rinc = 1'b0;
      chk("drain_udf", 32'(underflow), 0);

      // underflow with simultaneous write on empty
      rinc = 1'b1; winc = 1'b1; wdata = 8'hA5;
      tick();
      winc = 1'b0;
      chk("udf_set", 32'(underflow), 1);
      chk("udf_count", 32'(count), 1);
      chk("udf_rdata_hold", 32'(rdata), 32'h0F);
      chk("udf_rempty", 32'(rempty), 0);
      tick();
      rinc = 1'b0;
      chk("udf_next_rdata", 32'(rdata), 32'hA5);
      chk("udf_next_count", 32'(count), 0);
      // set wins over clear in the same cycle
      rinc = 1'b1; clr_err = 1'b1;
      tick();
      rinc = 1'b0;
      chk("udf_set_wins", 32'(underflow), 1);
      tick();
      clr_err = 1'b0;
      chk("udf_clr", 32'(underflow), 0);
      chk("udf_clr_rdata", 32'(rdata), 32'hA5);

      // full with simultaneous read and write
      for (int i = 0; i < 16; i++) begin
         winc = 1'b1; wdata = 8'(8'h10 + i);
         tick();
      end
      chk("fs_full_count", 32'(count), 16);
      winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
      tick();
      winc = 1'b0;
      chk("fs_rdata", 32'(rdata), 32'h10);
      chk("fs_count", 32'(count), 16);
      chk("fs_wfull", 32'(wfull), 1);
      chk("fs_ovf", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("fs_drain", 32'(rdata), (i == 15) ? 32'h55 : 32'(8'h11 + i));
      end
      rinc = 1'b0;
      chk("fs_empty", 32'(rempty), 1);

      // wrap-around at occupancy 3
      for (int i = 0; i < 3; i++) begin
         winc = 1'b1; wdata = 8'(8'h80 + i);
         tick();
      end
      chk("wrap_pre_count", 32'(count), 3);
      chk("wrap_pre_aempty", 32'(ralmost_empty), 0);
      for (int k = 0; k < 40; k++) begin
         winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h83 + k);
         tick();
         chk("wrap_rdata", 32'(rdata), 32'(8'(8'h80 + k)));
         chk("wrap_count", 32'(count), 3);
         chk("wrap_aempty", 32'(ralmost_empty), 0);
      end
      winc = 1'b0; rinc = 1'b0;

      // reset mid-operation ignores requests and flags
      rst_n = 1'b0; winc = 1'b1; rinc = 1'b1;
      tick();
      rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_rempty", 32'(rempty), 1);
      chk("mid_rst_rdata", 32'(rdata), 0);
      chk("mid_rst_udf", 32'(underflow), 0);
      chk("mid_rst_ovf", 32'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
